weight_stream_sink: RTL and testbench
=====================================

Name: weight_stream_sink

Overview:
- Receiving end of the weight-source streaming interface.
- Accepts a parallel weight stream on a valid/ready handshake and writes each beat into an internal RAM of IN_DEPTH words. Signals when a full tensor has been loaded.
- Exposes a registered random-access read port so a compute block can re-read weights any number of times.
- Sits between a streamed weight producer (DMA or source) and dense/linear compute units.

Parameters:
- WEIGHT_PRECISION_0, 16, bit width of one weight element.
- WEIGHT_TENSOR_SIZE_DIM_0, 32, tensor elements along dim 0.
- WEIGHT_PARALLELISM_DIM_0, 1, elements per beat along dim 0.
- WEIGHT_PARALLELISM_DIM_1, 1, elements per beat along dim 1.
- IN_DEPTH, WEIGHT_TENSOR_SIZE_DIM_0/WEIGHT_PARALLELISM_DIM_0, beats per tensor (RAM depth).
- ADDR_WIDTH, $clog2(IN_DEPTH)+1, width of pointers and read address.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- data_in  in  WEIGHT_PRECISION_0 x (PAR0*PAR1) array  one beat of weights.
- data_in_valid  in  1  beat valid.
- data_in_ready  out  1  sink can accept a beat.
- reload  in  1  single-cycle pulse; discard contents and restart loading.
- load_done  out  1  high while RAM holds a complete tensor.
- beat_count  out  ADDR_WIDTH  beats written in the current load.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read word address.
- rd_data  out  WEIGHT_PRECISION_0 x (PAR0*PAR1) array  read word, 1-cycle latency.

Behaviour:
- RAM word = concatenation of the data_in elements. Element j occupies bits [WEIGHT_PRECISION_0*j +: WEIGHT_PRECISION_0]. rd_data unpacks with the same rule.
- Reset (rst=0, asynchronous): state=LOAD, wr_ptr=0, beat_count=0, load_done=0, rd_data all zero. RAM contents are not cleared.
- FSM has two states: LOAD and FULL.
- LOAD:
  - data_in_ready = !reload (combinational).
  - A beat transfers when data_in_valid && data_in_ready. It writes RAM[wr_ptr], then wr_ptr and beat_count increment.
  - The transfer with wr_ptr==IN_DEPTH-1 moves the FSM to FULL next cycle. On that cycle wr_ptr=0, beat_count=IN_DEPTH, load_done=1.
- FULL:
  - data_in_ready=0 and load_done=1.
  - Incoming valid is held off (backpressure). No overwrite is possible.
- reload (either state):
  - Next cycle: state=LOAD, wr_ptr=0, beat_count=0, load_done=0.
  - A valid beat on the reload cycle is not accepted, because ready is low that cycle.
  - Reload during a partial load discards the partial beats.
- Read port:
  - Independent of FSM state.
  - rd_en=1 at cycle N: rd_data at N+1 = RAM[rd_addr].
  - rd_en=0: rd_data holds its previous value.
  - rd_addr >= IN_DEPTH: rd_data = 0 next cycle.
- Read and write to the same address in the same cycle: read returns the old contents (read-before-write).
- Throughput: one beat per cycle in LOAD. Back-to-back loads need one reload cycle plus IN_DEPTH beats.
- Reset asserted mid-load: immediate return to the reset values above. Beats already written remain in RAM but are not valid (load_done=0).

Test Plan:
- Reset, then stream 32 beats with values 0x0000..0x001F and valid held high. Expect ready=1 for 32 cycles; load_done=1 and beat_count=32 on the cycle after the 32nd transfer; ready=0 afterwards.
- After the full load, read addresses 0..31 back-to-back with rd_en=1. Expect rd_data = address value one cycle later; rd_addr=40 returns 0.
- Valid toggling 1,0,1,0 with random gaps. Expect exactly 32 transfers, no duplicates or drops, and load_done only after the 32nd.
- In FULL, hold valid=1 with value 0xFFFF for 10 cycles. Expect ready=0 throughout; RAM[0] still reads 0x0000.
- After 10 beats, pulse reload together with valid. Expect ready=0 that cycle, beat_count=0 next cycle, and a new stream of 0x1000+i fully overwrites the RAM.
- Assert rst low mid-load (beat 5) for one clock edge. Expect load_done=0, beat_count=0, rd_data=0, ready=1 after release.
- Write and read address 3 in the same cycle. Expect the old value, then the new value on the next read.

Source files
------------

// File: rtl/weight_stream_sink_if.sv
// weight_stream_sink_if
// Bundles the streamed weight input handshake, the load status outputs and
// the random-access read port of the weight stream sink.
//
// Signals (direction as seen by the sink, modport slave):
//   data_in        in   NUM_ELEM x DATA_WIDTH  one beat of weights
//   data_in_valid  in   1                      beat valid
//   data_in_ready  out  1                      sink can accept a beat
//   reload         in   1                      pulse: discard contents, restart loading
//   load_done      out  1                      RAM holds a complete tensor
//   beat_count     out  ADDR_WIDTH             beats written in the current load
//   rd_en          in   1                      read request
//   rd_addr        in   ADDR_WIDTH             read word address
//   rd_data        out  NUM_ELEM x DATA_WIDTH  read word, one cycle after rd_en
//
// The master modport is the producer/compute side driving the stream and
// issuing reads.
interface weight_stream_sink_if #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_ELEM   = 1,
   parameter int ADDR_WIDTH = 6
) ();

   logic [DATA_WIDTH-1:0] data_in [NUM_ELEM];
   logic                  data_in_valid;
   logic                  data_in_ready;
   logic                  reload;
   logic                  load_done;
   logic [ADDR_WIDTH-1:0] beat_count;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data [NUM_ELEM];

   modport master (
      output data_in,
      output data_in_valid,
      input  data_in_ready,
      output reload,
      input  load_done,
      input  beat_count,
      output rd_en,
      output rd_addr,
      input  rd_data
   );

   modport slave (
      input  data_in,
      input  data_in_valid,
      output data_in_ready,
      input  reload,
      output load_done,
      output beat_count,
      input  rd_en,
      input  rd_addr,
      output rd_data
   );

endinterface

// File: rtl/weight_stream_sink.sv
// weight_stream_sink
// Receiving end of the weight streaming interface. Each accepted beat is
// written into an internal RAM of IN_DEPTH words; once a whole tensor has
// arrived the sink raises load_done and holds off further beats until a
// reload pulse restarts loading. A registered read port lets a compute block
// re-read any stored word as often as it likes, independent of loading.
//
// Ports:
//   clk_i   in  1  clock, all state updates on the rising edge
//   rst_ni  in  1  asynchronous active-low reset
//   bus     weight_stream_sink_if.slave  stream, status and read port
//
// RAM words are the concatenation of the beat elements, element j in bits
// [WEIGHT_PRECISION_0*j +: WEIGHT_PRECISION_0]; reads unpack the same way.
module weight_stream_sink #(
   parameter int WEIGHT_PRECISION_0       = 16,
   parameter int WEIGHT_TENSOR_SIZE_DIM_0 = 32,
   parameter int WEIGHT_PARALLELISM_DIM_0 = 1,
   parameter int WEIGHT_PARALLELISM_DIM_1 = 1,
   parameter int IN_DEPTH   = WEIGHT_TENSOR_SIZE_DIM_0 / WEIGHT_PARALLELISM_DIM_0,
   parameter int ADDR_WIDTH = $clog2(IN_DEPTH) + 1
) (
   input logic clk_i,
   input logic rst_ni,
   weight_stream_sink_if.slave bus
);

   localparam int NUM_ELEM  = WEIGHT_PARALLELISM_DIM_0 * WEIGHT_PARALLELISM_DIM_1;
   localparam int WORD_W    = WEIGHT_PRECISION_0 * NUM_ELEM;
   localparam int MEM_AW    = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(IN_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(IN_DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

   typedef enum logic {
      LOAD,
      FULL
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
   logic [ADDR_WIDTH-1:0] beatCount_q, beatCount_d;
   logic                  loadDone_q, loadDone_d;
   logic [WORD_W-1:0]     rdData_q;
   logic [WORD_W-1:0]     mem_q [IN_DEPTH];

   logic              ready;
   logic              wrEn;
   logic [WORD_W-1:0] wrWord;
   logic              rdAddrOk;

   // Ready is purely combinational: the sink only takes beats while loading,
   // and a reload cycle never accepts a beat so the restart is clean.
   always_comb begin
      ready = (state_q == LOAD) && !bus.reload;
      wrEn  = bus.data_in_valid && ready;
   end

   // Flatten the beat's element array into one RAM word.
   always_comb begin
      wrWord = '0;
      for (int j = 0; j < NUM_ELEM; j++) begin
         wrWord[WEIGHT_PRECISION_0*j +: WEIGHT_PRECISION_0] = bus.data_in[j];
      end
   end

   // Next-state logic. Reload overrides everything; otherwise the last beat
   // of a tensor wraps the write pointer and parks the FSM in FULL, where
   // backpressure protects the stored tensor from being overwritten.
   always_comb begin
      state_d     = state_q;
      wrPtr_d     = wrPtr_q;
      beatCount_d = beatCount_q;
      loadDone_d  = loadDone_q;
      if (bus.reload) begin
         state_d     = LOAD;
         wrPtr_d     = '0;
         beatCount_d = '0;
         loadDone_d  = 1'b0;
      end else begin
         case (state_q)
            LOAD: begin
               if (wrEn) begin
                  if (wrPtr_q == LAST_A) begin
                     state_d     = FULL;
                     wrPtr_d     = '0;
                     beatCount_d = DEPTH_A;
                     loadDone_d  = 1'b1;
                  end else begin
                     wrPtr_d     = wrPtr_q + ONE_A;
                     beatCount_d = beatCount_q + ONE_A;
                  end
               end
            end
            FULL: begin
               loadDone_d = 1'b1;
            end
            default: begin
               state_d = LOAD;
            end
         endcase
      end
   end

   // Control state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= LOAD;
         wrPtr_q     <= '0;
         beatCount_q <= '0;
         loadDone_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wrPtr_q     <= wrPtr_d;
         beatCount_q <= beatCount_d;
         loadDone_q  <= loadDone_d;
      end
   end

   // Weight storage. Not reset: stale words survive a reset but are not
   // considered valid until a fresh load completes.
   always_ff @(posedge clk_i) begin
      if (wrEn) begin
         mem_q[wrPtr_q[MEM_AW-1:0]] <= wrWord;
      end
   end

   assign rdAddrOk = (bus.rd_addr < DEPTH_A);

   // Registered read port. Sampling the array with a non-blocking read gives
   // read-before-write when the same word is written in the same cycle.
   // Out-of-range addresses return zero rather than aliasing.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdData_q <= '0;
      end else if (bus.rd_en) begin
         if (rdAddrOk) begin
            rdData_q <= mem_q[bus.rd_addr[MEM_AW-1:0]];
         end else begin
            rdData_q <= '0;
         end
      end
   end

   assign bus.data_in_ready = ready;
   assign bus.load_done     = loadDone_q;
   assign bus.beat_count    = beatCount_q;

   // Unpack the read word into elements using the same layout as writes.
   for (genvar g = 0; g < NUM_ELEM; g++) begin : g_rdUnpack
      assign bus.rd_data[g] = rdData_q[WEIGHT_PRECISION_0*g +: WEIGHT_PRECISION_0];
   end

endmodule

// File: tb/tb_weight_stream_sink.sv
// tb_weight_stream_sink
// Directed bench for weight_stream_sink with the default 16-bit, 32-deep,
// one-element-per-beat configuration. Inputs change #1 after the rising
// edge and outputs are sampled at that same point.
module tb_weight_stream_sink;

   localparam int PREC  = 16;
   localparam int DEPTH = 32;
   localparam int AW    = 6;

   logic clk;
   logic rst_n;

   int testsRun  = 0;
   int failCount = 0;

   weight_stream_sink_if #(.DATA_WIDTH(PREC), .NUM_ELEM(1), .ADDR_WIDTH(AW)) bus ();

   weight_stream_sink #(
      .WEIGHT_PRECISION_0      (PREC),
      .WEIGHT_TENSOR_SIZE_DIM_0(DEPTH),
      .WEIGHT_PARALLELISM_DIM_0(1),
      .WEIGHT_PARALLELISM_DIM_1(1)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic [15:0] data,
                                input logic reload);
      bus.data_in_valid = valid;
      bus.data_in[0]    = data;
      bus.reload        = reload;
   endtask

   task automatic applyRead(input logic en, input logic [AW-1:0] addr);
      bus.rd_en   = en;
      bus.rd_addr = addr;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      int gap;
      applyStimulus(1'b0, 16'h0, 1'b0);
      applyRead(1'b0, '0);
      rst_n = 1'b0;
      tick();
      tick();

      // Reset state.
      checkOutput("rst_load_done", 32'(bus.load_done), 32'd0);
      checkOutput("rst_beat_count", 32'(bus.beat_count), 32'd0);
      checkOutput("rst_rd_data", 32'(bus.rd_data[0]), 32'd0);
      checkOutput("rst_ready", 32'(bus.data_in_ready), 32'd1);
      rst_n = 1'b1;
      tick();

      // Full load, valid held high, values 0..31.
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b1, 16'(i), 1'b0);
         checkOutput("load_ready", 32'(bus.data_in_ready), 32'd1);
         tick();
         checkOutput("load_count", 32'(bus.beat_count), 32'(i + 1));
         checkOutput("load_done_flag", 32'(bus.load_done), (i == DEPTH - 1) ? 32'd1 : 32'd0);
      end
      checkOutput("full_ready", 32'(bus.data_in_ready), 32'd0);
      applyStimulus(1'b0, 16'h0, 1'b0);

      // Back-to-back readback, then an out-of-range address.
      for (int a = 0; a < DEPTH; a++) begin
         applyRead(1'b1, AW'(a));
         tick();
         checkOutput("readback", 32'(bus.rd_data[0]), 32'(a));
      end
      applyRead(1'b1, AW'(40));
      tick();
      checkOutput("read_oob", 32'(bus.rd_data[0]), 32'd0);

      // rd_en low holds the previous read value.
      applyRead(1'b1, AW'(5));
      tick();
      applyRead(1'b0, AW'(7));
      tick();
      checkOutput("read_hold", 32'(bus.rd_data[0]), 32'd5);

      // Backpressure in FULL: nothing gets overwritten.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 16'hFFFF, 1'b0);
         checkOutput("full_backpressure", 32'(bus.data_in_ready), 32'd0);
         tick();
      end
      applyStimulus(1'b0, 16'h0, 1'b0);
      checkOutput("full_count_held", 32'(bus.beat_count), 32'd32);
      applyRead(1'b1, AW'(0));
      tick();
      checkOutput("full_ram0_intact", 32'(bus.rd_data[0]), 32'h0000);
      applyRead(1'b0, '0);

      // Reload from FULL, partial load of 10, then reload alongside valid.
      applyStimulus(1'b0, 16'h0, 1'b1);
      tick();
      applyStimulus(1'b0, 16'h0, 1'b0);
      checkOutput("reload_full_count", 32'(bus.beat_count), 32'd0);
      checkOutput("reload_full_done", 32'(bus.load_done), 32'd0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 16'h2000 + 16'(i), 1'b0);
         tick();
      end
      checkOutput("partial_count", 32'(bus.beat_count), 32'd10);
      applyStimulus(1'b1, 16'h2ABC, 1'b1);
      #1;
      checkOutput("reload_ready_low", 32'(bus.data_in_ready), 32'd0);
      tick();
      applyStimulus(1'b0, 16'h0, 1'b0);
      checkOutput("reload_count", 32'(bus.beat_count), 32'd0);
      checkOutput("reload_done", 32'(bus.load_done), 32'd0);

      // New stream 0x1000+i with random idle gaps between beats.
      for (int i = 0; i < DEPTH; i++) begin
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) begin
            applyStimulus(1'b0, 16'hDEAD, 1'b0);
            tick();
            checkOutput("gap_count", 32'(bus.beat_count), 32'(i));
         end
         applyStimulus(1'b1, 16'h1000 + 16'(i), 1'b0);
         checkOutput("gap_ready", 32'(bus.data_in_ready), 32'd1);
         tick();
         checkOutput("gap_done_flag", 32'(bus.load_done), (i == DEPTH - 1) ? 32'd1 : 32'd0);
      end
      applyStimulus(1'b0, 16'h0, 1'b0);
      checkOutput("gap_final_count", 32'(bus.beat_count), 32'd32);
      for (int a = 0; a < DEPTH; a++) begin
         applyRead(1'b1, AW'(a));
         tick();
         checkOutput("gap_readback", 32'(bus.rd_data[0]), 32'h1000 + 32'(a));
      end
      applyRead(1'b0, '0);

      // Reset mid-load after 5 beats of 0x3000+i.
      applyStimulus(1'b0, 16'h0, 1'b1);
      tick();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 16'h3000 + 16'(i), 1'b0);
         applyRead(1'b1, AW'(2));
         tick();
      end
      checkOutput("prereset_rd", 32'(bus.rd_data[0]), 32'h3002);
      applyStimulus(1'b1, 16'h3005, 1'b0);
      applyRead(1'b0, '0);
      #2;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      applyStimulus(1'b0, 16'h0, 1'b0);
      #1;
      checkOutput("midrst_done", 32'(bus.load_done), 32'd0);
      checkOutput("midrst_count", 32'(bus.beat_count), 32'd0);
      checkOutput("midrst_rd", 32'(bus.rd_data[0]), 32'd0);
      checkOutput("midrst_ready", 32'(bus.data_in_ready), 32'd1);
      tick();

      // Same-cycle write and read of address 3: old value, then new value.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 16'h4000 + 16'(i), 1'b0);
         tick();
      end
      applyStimulus(1'b1, 16'h4003, 1'b0);
      applyRead(1'b1, AW'(3));
      tick();
      applyStimulus(1'b0, 16'h0, 1'b0);
      checkOutput("rbw_old", 32'(bus.rd_data[0]), 32'h3003);
      tick();
      checkOutput("rbw_new", 32'(bus.rd_data[0]), 32'h4003);
      checkOutput("rbw_count", 32'(bus.beat_count), 32'd4);
      applyRead(1'b0, '0);
      tick();

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
